// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with oversampled timing, valid/ack handshake, framing and overrun flags
module uart_rx #(
    parameter int OVS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sync,
    input  logic       i_rx_in,
    input  logic       i_rx_ack,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_frame_err,
    output logic       o_rx_overrun
);
    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx_s;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic          w_bit_clr;
    logic          w_shift_en;
    logic          w_load;
    logic          w_ferr;

    assign w_rx_s = r_sync2;

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_sync) begin
            case (r_state)
                S_IDLE:  if (!w_rx_s) w_next = S_START;
                S_START: if (r_cnt == HALF_M1) w_next = w_rx_s ? S_IDLE : S_DATA;
                S_DATA:  if (r_cnt == FULL_M1 && r_bit == 3'd7) w_next = S_STOP;
                S_STOP:  if (r_cnt == FULL_M1) w_next = w_rx_s ? S_IDLE : S_BREAK;
                S_BREAK: if (w_rx_s) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_bit_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_load     = 1'b0;
        w_ferr     = 1'b0;
        if (i_sync) begin
            case (r_state)
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        w_cnt_clr = 1'b1;
                        w_bit_clr = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        w_cnt_clr  = 1'b1;
                        w_shift_en = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        w_cnt_clr = 1'b1;
                        w_load    = w_rx_s;
                        w_ferr    = !w_rx_s;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                default: w_cnt_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
            if (w_bit_clr)       r_bit <= 3'd0;
            else if (w_shift_en) r_bit <= r_bit + 3'd1;
            if (w_shift_en) r_shift <= {w_rx_s, r_shift[7:1]};
        end
    end

    // A load in the same clk as ack retires the old byte; overrun only when nobody acked.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_data      <= 8'h00;
            o_rx_valid     <= 1'b0;
            o_rx_frame_err <= 1'b0;
            o_rx_overrun   <= 1'b0;
        end else begin
            o_rx_frame_err <= w_ferr;
            if (w_load) begin
                o_rx_data  <= r_shift;
                o_rx_valid <= 1'b1;
                if (i_rx_ack)        o_rx_overrun <= 1'b0;
                else if (o_rx_valid) o_rx_overrun <= 1'b1;
            end else if (i_rx_ack) begin
                o_rx_valid   <= 1'b0;
                o_rx_overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed 8N1 frames
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_ack = 1'b0;
    logic       man_ack = 1'b0;
    logic       auto_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        logic       ovr;
    } exp_t;
    exp_t exp_q[$];

    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_ferr = 1'b0;

    uart_rx #(.OVS(16)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_sync(sync),
        .i_rx_in(rx_in),
        .i_rx_ack(rx_ack),
        .o_rx_data(rx_data),
        .o_rx_valid(rx_valid),
        .o_rx_frame_err(rx_frame_err),
        .o_rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        sync = cyc[0];
        rx_ack = man_ack || (auto_ack && rx_valid && !rx_ack);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic ovr);
        exp_t e;
        e.ferr = 1'b0;
        e.data = d;
        e.ovr = ovr;
        exp_q.push_back(e);
    endtask

    task automatic push_ferr();
        exp_t e;
        e.ferr = 1'b1;
        e.data = 8'h00;
        e.ovr = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!sync) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        #1 rx_in = b;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        send_bit(stop, 16);
    endtask

    task automatic do_ack();
        @(posedge clk);
        #1 man_ack = 1'b1;
        @(posedge clk);
        #1 man_ack = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: every byte load or framing-error pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rx_frame_err) begin
                chk("ferr_width", {31'd0, prev_ferr}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ferr", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ferr_kind", {31'd0, e.ferr}, 32'd1);
                end
            end
            if (rx_valid && (!prev_valid || rx_data != prev_data)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, rx_data}, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_kind", {31'd0, e.ferr}, 32'd0);
                    chk("byte_data", {24'd0, rx_data}, {24'd0, e.data});
                    chk("byte_overrun", {31'd0, rx_overrun}, {31'd0, e.ovr});
                end
            end
        end
        prev_valid = rx_valid;
        prev_data = rx_data;
        prev_ferr = rx_frame_err;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        chk("reset_data", {24'd0, rx_data}, 32'h00);
        chk("reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_ferr", {31'd0, rx_frame_err}, 32'd0);
        chk("reset_overrun", {31'd0, rx_overrun}, 32'd0);
        rst_n = 1'b1;
        send_bit(1'b1, 20);

        push_byte(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1);
        chk("t1_valid", {31'd0, rx_valid}, 32'd1);
        chk("t1_data", {24'd0, rx_data}, 32'hA5);
        do_ack();
        chk("t1_ack_valid", {31'd0, rx_valid}, 32'd0);

        auto_ack = 1'b1;
        push_byte(8'h00, 1'b0);
        push_byte(8'hFF, 1'b0);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1, 8);
        auto_ack = 1'b0;
        chk("t2_valid", {31'd0, rx_valid}, 32'd0);
        chk("t2_overrun", {31'd0, rx_overrun}, 32'd0);

        push_byte(8'h3C, 1'b0);
        push_byte(8'h81, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        chk("t3_data", {24'd0, rx_data}, 32'h81);
        chk("t3_overrun", {31'd0, rx_overrun}, 32'd1);
        do_ack();
        chk("t3_ack_valid", {31'd0, rx_valid}, 32'd0);
        chk("t3_ack_overrun", {31'd0, rx_overrun}, 32'd0);

        push_ferr();
        send_frame(8'h55, 1'b0);
        send_bit(1'b0, 48);
        chk("t4_valid", {31'd0, rx_valid}, 32'd0);
        send_bit(1'b1, 32);
        push_byte(8'h12, 1'b0);
        send_frame(8'h12, 1'b1);
        chk("t4_data", {24'd0, rx_data}, 32'h12);
        do_ack();

        send_bit(1'b0, 4);
        send_bit(1'b1, 48);
        chk("t5_valid", {31'd0, rx_valid}, 32'd0);
        chk("t5_overrun", {31'd0, rx_overrun}, 32'd0);

        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 8);
        #1 rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_rst_data", {24'd0, rx_data}, 32'h00);
        chk("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("t6_rst_overrun", {31'd0, rx_overrun}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_bit(1'b1, 32);
        push_byte(8'h7E, 1'b0);
        send_frame(8'h7E, 1'b1);
        chk("t6_valid", {31'd0, rx_valid}, 32'd1);
        chk("t6_data", {24'd0, rx_data}, 32'h7E);

        repeat (10) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
